// File: rtl/in_dev_port.sv
// Buffered input-device port: a FIFO of upstream bytes, presented one at a time
// to the processor over the four-phase in_dev_hs / in_dev_ack handshake.
module in_dev_port #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     g_clk,
  input  logic                     g_clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     in_dev_ack,
  input  logic                     ovf_clr,
  output logic [WIDTH-1:0]         input_bus,
  output logic                     in_dev_hs,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRESENT = 2'b01,
    RELEASE = 2'b10
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            push;
  logic            pop;

  assign count = cnt;
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // Push is judged on pre-edge fullness; a same-cycle pop never makes room.
  assign push = wr_en && !full;
  assign pop  = (state == PRESENT) && in_dev_ack;

  // Storage array carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge g_clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
      // A rejected push wins over a same-cycle clear.
      if (wr_en && full) overflow <= 1'b1;
      else if (ovf_clr)  overflow <= 1'b0;
    end
  end

  // Handshake FSM; input_bus only changes on IDLE->PRESENT so it is stable while hs is high.
  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      state     <= IDLE;
      in_dev_hs <= 1'b0;
      input_bus <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_dev_hs <= 1'b0;
          if (!empty && !in_dev_ack) begin
            input_bus <= mem[rd_ptr];
            in_dev_hs <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (in_dev_ack) begin
            in_dev_hs <= 1'b0;
            state     <= RELEASE;
          end
        end
        RELEASE: begin
          in_dev_hs <= 1'b0;
          if (!in_dev_ack) state <= IDLE;
        end
        default: begin
          in_dev_hs <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/in_dev_port.md
# in_dev_port

Buffered input-device port that feeds the accumulator processor's `input_bus`. An upstream source (switches, UART receiver, testbench) pushes bytes into an internal FIFO. The port presents them one at a time to the processor over the four-phase `in_dev_hs` / `in_dev_ack` handshake that the processor's stage-1 controller consumes. Instantiated beside the processor at top level; its `input_bus` and `in_dev_hs` drive the processor inputs of the same names, and it receives the processor's `in_dev_ack`.

## Interface
- `WIDTH`, 8, data byte width (matches processor data path)
- `DEPTH`, 8, FIFO entries; must be a power of two, 2..16
- `g_clk` input 1: global clock; all state changes on the rising edge
- `g_clr` input 1: global clear. One clock; reset is asynchronous and active-high.
- `wr_en` input 1: upstream push request, sampled on the rising edge
- `wr_data` input WIDTH: upstream byte, sampled with `wr_en`
- `in_dev_ack` input 1: from the processor; high means the processor has latched `input_bus`
- `ovf_clr` input 1: synchronous clear of the sticky overflow flag
- `input_bus` output WIDTH: byte presented to the processor (registered)
- `in_dev_hs` output 1: data-ready to the processor (registered)
- `full` output 1: count == DEPTH
- `empty` output 1: count == 0
- `count` output $clog2(DEPTH)+1: current FIFO occupancy
- `overflow` output 1: sticky; a push was attempted while full

## Operation
- **FIFO:** circular buffer with read and write pointers of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH, and `count` tracks occupancy.
- **Push:** accepted when `wr_en`=1 and `full`=0, judged on pre-edge state. A push while full is dropped and sets `overflow`. A pop in the same cycle does not make room for it.
- **Overflow flag:** `ovf_clr`=1 clears `overflow`. If `ovf_clr` and a rejected push occur in the same cycle, `overflow` ends at 1.
- **Handshake FSM** (three states, encoded 2'b00 / 01 / 10):
  - **IDLE:** `in_dev_hs`=0. If `empty`=0 and `in_dev_ack`=0 → load `input_bus` with the FIFO head and go to PRESENT. Otherwise stay.
  - **PRESENT:** `in_dev_hs`=1, `input_bus` held stable. If `in_dev_ack`=1 → pop the FIFO (read pointer +1, count −1) and go to RELEASE. Otherwise stay, with no timeout.
  - **RELEASE:** `in_dev_hs`=0, `input_bus` holds the last byte. If `in_dev_ack`=0 → IDLE. Otherwise stay.
- **Same-cycle push and pop** (PRESENT with ack, FIFO not full): count is unchanged and both pointers advance.
- **Data stability:** `input_bus` changes only on the IDLE→PRESENT transition, so the byte is stable for the entire time `in_dev_hs`=1.
- **Ack while idle:** an `in_dev_ack` that is high in IDLE blocks presentation until it falls. This prevents a stale ack from popping a byte.
- Unused encoding 2'b11 → IDLE on the next edge.

## Timing
- **Reset values** (immediately on `g_clr` assertion, no clock needed):
  - `input_bus`=0, `in_dev_hs`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0
  - FSM=IDLE, both pointers=0
- **Reset mid-transfer:** `in_dev_hs` drops asynchronously and all buffered bytes are discarded.
- **Latency:** byte pushed at edge N into an empty FIFO, FSM in IDLE, ack low:
  - `count`=1 after edge N
  - `in_dev_hs`=1 and `input_bus`=byte after edge N+1
- **Pop:** `in_dev_ack` sampled high at edge M in PRESENT → `in_dev_hs`=0 and `count` decremented after edge M.
- **Back-to-back bytes:** ack falls before edge K → IDLE after edge K → next byte presented after edge K+1. Minimum 3 cycles per byte when ack is held for exactly one cycle each phase.
- `full`, `empty` and `count` are combinational from registered state. They reflect post-edge values.
- All inputs are assumed synchronous to `g_clk`. No synchronizers are inside this block.

## Test plan
- **Reset:** push 3 bytes, assert `g_clr` mid-PRESENT → `in_dev_hs`, `count`, `input_bus` all 0 immediately. After release, no handshake begins without new pushes.
- **Single transfer:** push 0xA5 at edge 1 → `in_dev_hs`=1 and `input_bus`=0xA5 after edge 2. Raise ack at edge 5 → `hs`=0 and `count`=0 after edge 5. Drop ack at edge 7 → IDLE, `hs` stays 0.
- **Order and wrap:** push 0x01..0x0C interleaved with pops, DEPTH=8, so pointers wrap at least once → processor-side model receives 0x01..0x0C in order, with no duplicates.
- **Full and overflow:** push 9 bytes with no ack → `full`=1, `count`=8, `overflow`=1. The 9th byte never appears. Pulse `ovf_clr` → `overflow`=0. Ack 8 times → bytes 1..8 delivered, then `empty`=1.
- **Simultaneous push and pop** at count=4 → `count` stays 4 and the pushed byte is delivered fifth.
- **Stale ack:** hold `in_dev_ack`=1, then push 0x3C → `in_dev_hs` stays 0 and `count`=1. Drop ack → `hs`=1 one edge later with 0x3C.
